// File: rtl/vtx_trace_pkg.sv
// Shared constants and FSM encoding for the coprocessor trace-capture block.
package vtx_trace_pkg;

    localparam int NCPRS      = 16;
    localparam int XLEN       = 32;
    localparam int CPR_FLAT_W = NCPRS * XLEN;
    localparam int RESULT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_POST = 2'd2
    } trace_state_e;

endpackage

// File: rtl/vtx_snap_bank.sv
// Wide snapshot register with load enable and synchronous clear.
module vtx_snap_bank #(
    parameter int W = vtx_trace_pkg::CPR_FLAT_W
) (
    input  logic         g_clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge g_clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/vtx_trace_capture.sv
// Passive trace capture: records one coprocessor instruction at a time with
// CPR-file snapshots taken before issue and after retire.
module vtx_trace_capture #(
    parameter int NCPRS = 16,
    parameter int XLEN  = 32
) (
    input  logic                                g_clk,
    input  logic                                g_resetn,
    input  logic                                cop_insn_valid,
    input  logic                                cop_insn_ready,
    input  logic [31:0]                         cop_insn_enc,
    input  logic [XLEN-1:0]                     cop_insn_rs1,
    input  logic                                cop_wb_valid,
    input  logic [vtx_trace_pkg::RESULT_W-1:0]  cop_wb_result,
    input  logic                                cop_wb_wen,
    input  logic [4:0]                          cop_wb_waddr,
    input  logic [XLEN-1:0]                     cop_wb_wdata,
    input  logic [NCPRS*XLEN-1:0]               cprs_flat,
    output logic                                vtx_valid,
    output logic                                vtx_reset,
    output logic [31:0]                         vtx_instr_enc,
    output logic [XLEN-1:0]                     vtx_instr_rs1,
    output logic [vtx_trace_pkg::RESULT_W-1:0]  vtx_instr_result,
    output logic [XLEN-1:0]                     vtx_instr_wdata,
    output logic [4:0]                          vtx_instr_waddr,
    output logic                                vtx_instr_wen,
    output logic [NCPRS*XLEN-1:0]               vtx_cprs_pre,
    output logic [NCPRS*XLEN-1:0]               vtx_cprs_post,
    output logic                                trace_err
);

    import vtx_trace_pkg::*;

    localparam int FLAT_W = NCPRS * XLEN;

    trace_state_e        state;
    logic                pend_issue;
    logic                reset_d;
    logic [31:0]         cur_enc;
    logic [XLEN-1:0]     cur_rs1;
    logic [31:0]         stg_enc;
    logic [XLEN-1:0]     stg_rs1;
    logic [RESULT_W-1:0] cur_result;
    logic                cur_wen;
    logic [4:0]          cur_waddr;
    logic [XLEN-1:0]     cur_wdata;
    logic [FLAT_W-1:0]   stage_pre;

    logic issue_fire;
    logic snap_clear;
    logic stage_load;
    logic emit_load;

    assign issue_fire = cop_insn_valid & cop_insn_ready;
    assign snap_clear = ~g_resetn;
    assign emit_load  = (state == ST_POST);
    // The in-flight pre snapshot is always taken from the live file, whether at a
    // fresh issue or for an instruction that was staged during the previous retire.
    assign stage_load = ((state == ST_IDLE) && issue_fire) ||
                        ((state == ST_POST) && (pend_issue || issue_fire));

    vtx_snap_bank #(.W(FLAT_W)) u_stage_bank (
        .g_clk (g_clk),
        .clear (snap_clear),
        .load  (stage_load),
        .d     (cprs_flat),
        .q     (stage_pre)
    );

    vtx_snap_bank #(.W(FLAT_W)) u_pre_bank (
        .g_clk (g_clk),
        .clear (snap_clear),
        .load  (emit_load),
        .d     (stage_pre),
        .q     (vtx_cprs_pre)
    );

    vtx_snap_bank #(.W(FLAT_W)) u_post_bank (
        .g_clk (g_clk),
        .clear (snap_clear),
        .load  (emit_load),
        .d     (cprs_flat),
        .q     (vtx_cprs_post)
    );

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state            <= ST_IDLE;
            pend_issue       <= 1'b0;
            reset_d          <= 1'b1;
            vtx_reset        <= 1'b1;
            vtx_valid        <= 1'b0;
            trace_err        <= 1'b0;
            cur_enc          <= '0;
            cur_rs1          <= '0;
            stg_enc          <= '0;
            stg_rs1          <= '0;
            cur_result       <= '0;
            cur_wen          <= 1'b0;
            cur_waddr        <= '0;
            cur_wdata        <= '0;
            vtx_instr_enc    <= '0;
            vtx_instr_rs1    <= '0;
            vtx_instr_result <= '0;
            vtx_instr_wen    <= 1'b0;
            vtx_instr_waddr  <= '0;
            vtx_instr_wdata  <= '0;
        end else begin
            reset_d   <= 1'b0;
            vtx_reset <= reset_d;
            vtx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cop_wb_valid) begin
                        trace_err <= 1'b1;
                    end
                    if (issue_fire) begin
                        cur_enc <= cop_insn_enc;
                        cur_rs1 <= cop_insn_rs1;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cop_wb_valid) begin
                        cur_result <= cop_wb_result;
                        cur_wen    <= cop_wb_wen;
                        cur_waddr  <= cop_wb_waddr;
                        cur_wdata  <= cop_wb_wdata;
                        state      <= ST_POST;
                        if (issue_fire) begin
                            pend_issue <= 1'b1;
                            stg_enc    <= cop_insn_enc;
                            stg_rs1    <= cop_insn_rs1;
                        end
                    end else if (issue_fire) begin
                        trace_err <= 1'b1;
                    end
                end
                ST_POST: begin
                    // Output registers only change here, so they hold between pulses.
                    vtx_valid        <= 1'b1;
                    vtx_instr_enc    <= cur_enc;
                    vtx_instr_rs1    <= cur_rs1;
                    vtx_instr_result <= cur_result;
                    vtx_instr_wen    <= cur_wen;
                    vtx_instr_waddr  <= cur_waddr;
                    vtx_instr_wdata  <= cur_wdata;
                    if (cop_wb_valid) begin
                        trace_err <= 1'b1;
                    end
                    if (pend_issue) begin
                        cur_enc    <= stg_enc;
                        cur_rs1    <= stg_rs1;
                        pend_issue <= 1'b0;
                        state      <= ST_BUSY;
                        if (issue_fire) begin
                            trace_err <= 1'b1;
                        end
                    end else if (issue_fire) begin
                        cur_enc <= cop_insn_enc;
                        cur_rs1 <= cop_insn_rs1;
                        state   <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
